// File: rtl/DMNIPkg.sv
// DMNIPkg: shared types for the DMNI BrLite send path.
// Provides br_payload_t (the message a requester hands to BrLite)
// and the encoding of the arbiter's debug state output.
package DMNIPkg;

    typedef struct packed {
        logic [3:0]  ksvc;        // kernel service code
        logic [15:0] seq_source;  // sequence number / source address
        logic [31:0] payload;     // message body
    } br_payload_t;

    localparam int BR_PAYLOAD_W = $bits(br_payload_t);

    // Encoding seen on br_send_arbiter.dbg_state_o
    localparam logic [1:0] DBG_IDLE    = 2'd0;
    localparam logic [1:0] DBG_SEND    = 2'd1;
    localparam logic [1:0] DBG_RELEASE = 2'd2;

endpackage

// File: rtl/br_send_arbiter_if.sv
// br_send_arbiter_if: BrLite local send port bundle.
// Handshake: the master raises br_req and holds br_data stable until
// the slave answers with a br_ack pulse (or the master gives up); br_busy
// tells the master not to start a new request.
//   br_req  : master -> slave, send request
//   br_data : master -> slave, payload
//   br_ack  : slave -> master, accept pulse
//   br_busy : slave -> master, local port busy
interface br_send_arbiter_if;
    import DMNIPkg::*;

    logic        br_req;
    br_payload_t br_data;
    logic        br_ack;
    logic        br_busy;

    modport master (output br_req, output br_data, input br_ack, input br_busy);
    modport slave  (input br_req, input br_data, output br_ack, output br_busy);

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
// Scans req_i starting at ptr_i+1 and wrapping at N; returns the first
// set requester.
//   req_i   : request vector
//   ptr_i   : index of the last served requester
//   valid_o : at least one request present
//   idx_o   : winning requester index
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    logic [IW-1:0] cand;

    // Walk from the farthest offset back to the nearest so the nearest
    // requester after ptr_i is the last (winning) assignment.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int i = N; i >= 1; i--) begin
            cand = IW'((int'(ptr_i) + i) % N);
            if (req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/br_send_arbiter.sv
// br_send_arbiter: shares the BrLite local send port among N_REQ requesters.
// A requester raises req_i[k] with data_i[k] and holds both until it sees
// ack_o[k] (accepted) or err_o[k] (dropped after TIMEOUT_CYC cycles).
//   clk_i, rst_ni      : clock, synchronous active-low reset
//   req_i, data_i      : per-requester request and payload
//   ack_o, err_o       : per-requester one-cycle completion pulses
//   br_local_busy_i    : BrLite busy, blocks new grants
//   br_req_o/br_data_o : BrLite send request and payload
//   br_ack_i           : BrLite acknowledge
//   grant_id_o         : current / last granted requester
//   dbg_state_o        : FSM state (DMNIPkg::DBG_*)
module br_send_arbiter
    import DMNIPkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [N_REQ-1:0]         req_i,
    input  br_payload_t              data_i [N_REQ],
    output logic [N_REQ-1:0]         ack_o,
    output logic [N_REQ-1:0]         err_o,
    input  logic                     br_local_busy_i,
    output logic                     br_req_o,
    input  logic                     br_ack_i,
    output br_payload_t              br_data_o,
    output logic [$clog2(N_REQ)-1:0] grant_id_o,
    output logic [1:0]               dbg_state_o
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_req_q, br_req_d;
    br_payload_t      br_data_q, br_data_d;
    logic [IW-1:0]    grant_q, grant_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [N_REQ-1:0] err_q, err_d;

    logic             arb_valid;
    logic [IW-1:0]    arb_idx;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .valid_o (arb_valid),
        .idx_o   (arb_idx)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        br_req_d  = br_req_q;
        br_data_d = br_data_q;
        grant_d   = grant_q;
        ack_d     = '0;
        err_d     = '0;
        case (state_q)
            IDLE: begin
                if (arb_valid && !br_local_busy_i) begin
                    state_d   = SEND;
                    br_data_d = data_i[arb_idx];
                    grant_d   = arb_idx;
                    br_req_d  = 1'b1;
                    cnt_d     = '0;
                end
            end
            SEND: begin
                // Acknowledge is checked first so it beats a coincident timeout.
                if (br_ack_i) begin
                    br_req_d       = 1'b0;
                    ack_d[grant_q] = 1'b1;
                    ptr_d          = grant_q;
                    state_d        = RELEASE;
                end else if (cnt_q == TMO_LAST) begin
                    br_req_d       = 1'b0;
                    err_d[grant_q] = 1'b1;
                    ptr_d          = grant_q;
                    state_d        = RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                // Gives the served requester one cycle to drop its request.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            ptr_q     <= IW'(N_REQ - 1);
            cnt_q     <= '0;
            br_req_q  <= 1'b0;
            br_data_q <= '0;
            grant_q   <= '0;
            ack_q     <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            br_req_q  <= br_req_d;
            br_data_q <= br_data_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    assign br_req_o    = br_req_q;
    assign br_data_o   = br_data_q;
    assign grant_id_o  = grant_q;
    assign ack_o       = ack_q;
    assign err_o       = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_br_send_arbiter.sv
module tb_br_send_arbiter;
    import DMNIPkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- DUT A: N_REQ=2, TIMEOUT_CYC=4 ----------------
    br_send_arbiter_if bra ();
    logic [1:0]  a_req = '0;
    br_payload_t a_data [2];
    logic [1:0]  a_ack, a_err;
    logic [0:0]  a_gid;
    logic [1:0]  a_st;

    br_send_arbiter #(.N_REQ(2), .TIMEOUT_CYC(4)) dut_a (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_i           (a_req),
        .data_i          (a_data),
        .ack_o           (a_ack),
        .err_o           (a_err),
        .br_local_busy_i (bra.br_busy),
        .br_req_o        (bra.br_req),
        .br_ack_i        (bra.br_ack),
        .br_data_o       (bra.br_data),
        .grant_id_o      (a_gid),
        .dbg_state_o     (a_st)
    );

    // ---------------- DUT B: N_REQ=4, TIMEOUT_CYC=8 ----------------
    br_send_arbiter_if brb ();
    logic [3:0]  b_req = '0;
    br_payload_t b_data [4];
    logic [3:0]  b_ack, b_err;
    logic [1:0]  b_gid;
    logic [1:0]  b_st;

    br_send_arbiter #(.N_REQ(4), .TIMEOUT_CYC(8)) dut_b (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_i           (b_req),
        .data_i          (b_data),
        .ack_o           (b_ack),
        .err_o           (b_err),
        .br_local_busy_i (brb.br_busy),
        .br_req_o        (brb.br_req),
        .br_ack_i        (brb.br_ack),
        .br_data_o       (brb.br_data),
        .grant_id_o      (b_gid),
        .dbg_state_o     (b_st)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    br_payload_t d0, d1, d0k5;

    initial begin
        d0   = '{ksvc: 4'h1, seq_source: 16'h0010, payload: 32'hA0A0_0000};
        d1   = '{ksvc: 4'h2, seq_source: 16'h0021, payload: 32'hB1B1_1111};
        d0k5 = '{ksvc: 4'h5, seq_source: 16'h0055, payload: 32'h5555_AAAA};
        a_data[0] = d0;
        a_data[1] = d1;
        for (int i = 0; i < 4; i++)
            b_data[i] = '{ksvc: 4'(i + 8), seq_source: 16'(i), payload: 32'hC000_0000 + 32'(i)};
        bra.br_ack = 1'b0; bra.br_busy = 1'b0;
        brb.br_ack = 1'b0; brb.br_busy = 1'b0;

        // ---- reset ----
        rst_n = 1'b0;
        tick(); tick();
        check("rst_br_req", 64'(bra.br_req), 64'd0);
        check("rst_br_data", 64'(bra.br_data), 64'd0);
        check("rst_grant", 64'(a_gid), 64'd0);
        check("rst_ack", 64'(a_ack), 64'd0);
        check("rst_err", 64'(a_err), 64'd0);
        check("rst_state", 64'(a_st), 64'(DBG_IDLE));
        rst_n = 1'b1;
        tick();

        // ---- both request: requester 0 first, then 1 ----
        a_req = 2'b11;
        check("idle_no_req_yet", 64'(bra.br_req), 64'd0);
        tick();
        check("g0_state", 64'(a_st), 64'(DBG_SEND));
        check("g0_br_req", 64'(bra.br_req), 64'd1);
        check("g0_grant", 64'(a_gid), 64'd0);
        check("g0_data", 64'(bra.br_data), 64'(d0));
        bra.br_ack = 1'b1;
        tick();
        check("g0_ack", 64'(a_ack), 64'b01);
        check("g0_err", 64'(a_err), 64'd0);
        check("g0_req_drop", 64'(bra.br_req), 64'd0);
        check("g0_release", 64'(a_st), 64'(DBG_RELEASE));
        bra.br_ack = 1'b0;
        a_req = 2'b10;
        tick();
        check("rel_no_grant", 64'(bra.br_req), 64'd0);
        check("rel_ack_clear", 64'(a_ack), 64'd0);
        check("rel_to_idle", 64'(a_st), 64'(DBG_IDLE));
        tick();
        check("g1_grant", 64'(a_gid), 64'd1);
        check("g1_data", 64'(bra.br_data), 64'(d1));
        check("g1_br_req", 64'(bra.br_req), 64'd1);
        bra.br_ack = 1'b1;
        tick();
        check("g1_ack", 64'(a_ack), 64'b10);
        bra.br_ack = 1'b0;
        a_req = 2'b00;
        tick();

        // ---- ack while idle is ignored ----
        bra.br_ack = 1'b1;
        tick();
        check("idle_ack_ignored", 64'(a_ack), 64'd0);
        check("idle_ack_state", 64'(a_st), 64'(DBG_IDLE));
        bra.br_ack = 1'b0;

        // ---- busy blocks grants ----
        a_req = 2'b10;
        bra.br_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("busy_hold", 64'(bra.br_req), 64'd0);
        end
        bra.br_busy = 1'b0;
        tick();
        check("busy_release_req", 64'(bra.br_req), 64'd1);
        check("busy_release_data", 64'(bra.br_data), 64'(d1));
        bra.br_ack = 1'b1;
        tick();
        bra.br_ack = 1'b0;
        a_req = 2'b00;
        tick();

        // ---- timeout on requester 0 (last served was 1) ----
        a_req = 2'b11;
        tick();
        check("to_grant", 64'(a_gid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_still_req", 64'(bra.br_req), 64'd1);
            check("to_no_err_yet", 64'(a_err), 64'd0);
        end
        tick();
        check("to_req_drop", 64'(bra.br_req), 64'd0);
        check("to_err", 64'(a_err), 64'b01);
        check("to_no_ack", 64'(a_ack), 64'd0);
        a_req = 2'b10;
        tick();
        check("to_err_one_cycle", 64'(a_err), 64'd0);
        tick();
        check("to_next_grant", 64'(a_gid), 64'd1);
        check("to_next_req", 64'(bra.br_req), 64'd1);

        // ---- busy rising in SEND does not abort; ack on timeout cycle wins ----
        bra.br_busy = 1'b1;
        tick();
        check("busy_in_send", 64'(bra.br_req), 64'd1);
        tick(); tick();
        check("busy_in_send2", 64'(bra.br_req), 64'd1);
        bra.br_ack = 1'b1;
        tick();
        check("race_ack", 64'(a_ack), 64'b10);
        check("race_err", 64'(a_err), 64'd0);
        bra.br_ack = 1'b0;
        bra.br_busy = 1'b0;
        a_req = 2'b00;
        tick(); tick();

        // ---- reset mid-SEND ----
        a_data[0] = d0k5;
        a_req = 2'b01;
        tick();
        check("rs_send_data", 64'(bra.br_data), 64'(d0k5));
        tick();
        rst_n = 1'b0;
        tick();
        check("rs_req", 64'(bra.br_req), 64'd0);
        check("rs_data", 64'(bra.br_data), 64'd0);
        check("rs_ack", 64'(a_ack), 64'd0);
        check("rs_err", 64'(a_err), 64'd0);
        check("rs_state", 64'(a_st), 64'(DBG_IDLE));
        rst_n = 1'b1;
        a_req = 2'b11;
        tick();
        check("rs_first_grant", 64'(a_gid), 64'd0);
        bra.br_ack = 1'b1;
        tick();
        check("rs_ack_after", 64'(a_ack), 64'b01);
        bra.br_ack = 1'b0;
        a_req = 2'b00;
        tick(); tick();

        // ---- DUT B: four requesters, round-robin order 0,1,2,3,0 ----
        b_req = 4'hF;
        for (int g = 0; g < 5; g++) begin
            tick();
            check("rr_state_send", 64'(b_st), 64'(DBG_SEND));
            check("rr_grant", 64'(b_gid), 64'(g % 4));
            check("rr_data", 64'(brb.br_data), 64'(b_data[g % 4]));
            tick();
            check("rr_hold", 64'(brb.br_req), 64'd1);
            brb.br_ack = 1'b1;
            tick();
            check("rr_ack", 64'(b_ack), 64'(4'b0001 << (g % 4)));
            check("rr_release", 64'(b_st), 64'(DBG_RELEASE));
            brb.br_ack = 1'b0;
            tick();
            check("rr_idle", 64'(b_st), 64'(DBG_IDLE));
            check("rr_idle_req", 64'(brb.br_req), 64'd0);
        end
        b_req = 4'h0;
        tick();

        // ---- final report ----
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
